hazard_scoreboard: RTL and testbench

// - Parametrised successor of the pipeline interlock. It sits beside the ID stage and checks NUM_RPORTS

---
 rtl/hazard_scoreboard_pkg.sv | 14 +
 rtl/hazard_busy_tbl.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register address, forwarding select and its encoding.
// The optional forwarding path in hazard_scoreboard is enabled with HAZARD_FWD_EN.
package hazard_pkg;
  localparam int unsigned REG_AW      = 5;
  localparam int unsigned NUM_STG_DEF = 3;
  localparam int unsigned SEL_W       = $clog2(NUM_STG_DEF + 1);

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [SEL_W-1:0]  fwd_sel_t;

  typedef enum fwd_sel_t {
    FWD_RF = '0
  } fwd_src_e;
endpackage

// File: rtl/hazard_busy_tbl.sv
// Busy-bit table for long-latency destinations plus the outstanding long-op counter.
// Optional forwarding (HAZARD_FWD_EN) lives in the top; this table is identical in both builds.
module hazard_busy_tbl
  import hazard_pkg::*;
#(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 3,
  parameter int unsigned MAX_LONG = 4,
  parameter int unsigned CNT_W    = $clog2(MAX_LONG + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       set_en,
  input  reg_addr_t                  set_addr,
  input  logic                       clr_en,
  input  reg_addr_t                  clr_addr,
  input  logic [NRD-1:0][REG_AW-1:0] rd_addr,
  output logic [NRD-1:0]             rd_busy,
  input  logic                       cnt_inc,
  input  logic                       cnt_dec,
  output logic [CNT_W-1:0]           long_cnt
);

  logic [NREGS-1:0] busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      long_cnt <= '0;
    end else begin
      // Clear first so a same-cycle set of the same register wins.
      if (clr_en && (32'(clr_addr) < NREGS)) busy[clr_addr] <= 1'b0;
      if (set_en && (32'(set_addr) < NREGS)) busy[set_addr] <= 1'b1;
      if (cnt_inc && !cnt_dec)      long_cnt <= long_cnt + CNT_W'(1);
      else if (cnt_dec && !cnt_inc) long_cnt <= long_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++)
      rd_busy[i] = (32'(rd_addr[i]) < NREGS) && busy[rd_addr[i]];
  end

  a_cnt_underflow: assert property (@(posedge clk) disable iff (reset)
    !(cnt_dec && !cnt_inc && long_cnt == '0));
  a_cnt_overflow: assert property (@(posedge clk) disable iff (reset)
    !(cnt_inc && !cnt_dec && long_cnt == CNT_W'(MAX_LONG)));

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection: stage-match priority, forwarding selects and scoreboard stalls.
// Define HAZARD_FWD_EN to forward ready stage results; otherwise any stage match interlocks.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned NUM_STG    = NUM_STG_DEF,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned MAX_LONG   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              id_valid,
  input  logic [NUM_RPORTS-1:0]             id_ren,
  input  logic [NUM_RPORTS-1:0][REG_AW-1:0] id_raddr,
  input  logic                              id_we,
  input  reg_addr_t                         id_dest,
  input  logic                              id_long_op,
  input  logic                              id_issue,
  input  logic [NUM_STG-1:0]                stg_valid,
  input  logic [NUM_STG-1:0]                stg_we,
  input  logic [NUM_STG-1:0][REG_AW-1:0]    stg_dest,
  input  logic [NUM_STG-1:0]                stg_rdy,
  input  logic                              long_wb_valid,
  input  reg_addr_t                         long_wb_dest,
  output logic                              block_id,
  output logic                              block_if,
  output logic                              br_stall,
  output fwd_sel_t [NUM_RPORTS-1:0]         fwd_sel
);

  localparam int unsigned CNT_W = $clog2(MAX_LONG + 1);

  logic [NUM_RPORTS-1:0][NUM_STG-1:0] match;
  logic [NUM_RPORTS:0][REG_AW-1:0]    rd_addr;
  logic [NUM_RPORTS:0]                rd_busy;
  logic [CNT_W-1:0]                   long_cnt;
  fwd_sel_t [NUM_RPORTS-1:0]          fwd_raw;
  logic stage_stall, raw_stall, waw_stall, cap_stall;
  logic long_accept;

  always_comb begin
    rd_addr = '0;
    for (int unsigned p = 0; p < NUM_RPORTS; p++) rd_addr[p] = id_raddr[p];
    rd_addr[NUM_RPORTS] = id_dest;
  end

  always_comb begin
    match = '0;
    for (int unsigned p = 0; p < NUM_RPORTS; p++)
      for (int unsigned k = 0; k < NUM_STG; k++)
        match[p][k] = stg_valid[k] && stg_we[k] && (stg_dest[k] != '0) &&
                      id_ren[p] && (stg_dest[k] == id_raddr[p]);
  end

`ifndef HAZARD_FWD_EN
  logic unused_stg_rdy;
  assign unused_stg_rdy = ^stg_rdy;
`endif

  // Only the youngest matching stage decides; older matches are shadowed by it.
  always_comb begin
    logic found;
    found       = 1'b0;
    stage_stall = 1'b0;
    raw_stall   = 1'b0;
    for (int unsigned p = 0; p < NUM_RPORTS; p++) begin
      fwd_raw[p] = FWD_RF;
      found      = 1'b0;
      for (int unsigned k = 0; k < NUM_STG; k++) begin
        if (!found && match[p][k]) begin
          found = 1'b1;
`ifdef HAZARD_FWD_EN
          if (stg_rdy[k]) fwd_raw[p] = fwd_sel_t'(k + 1);
          else            stage_stall = 1'b1;
`else
          stage_stall = 1'b1;
`endif
        end
      end
      if (id_ren[p] && rd_busy[p] && (id_raddr[p] != '0)) begin
        raw_stall  = 1'b1;
        fwd_raw[p] = FWD_RF;
      end
    end
  end

  assign waw_stall = id_we && rd_busy[NUM_RPORTS] && (id_dest != '0);
  assign cap_stall = id_long_op && (long_cnt == CNT_W'(MAX_LONG));

  always_comb begin
    block_id = !reset && id_valid && (stage_stall || raw_stall || waw_stall || cap_stall);
    block_if = block_id;
    br_stall = block_id;
    fwd_sel  = reset ? '0 : fwd_raw;
  end

  assign long_accept = id_valid && id_issue && id_long_op && !block_id;

  hazard_busy_tbl #(
    .NREGS    (NREGS),
    .NRD      (NUM_RPORTS + 1),
    .MAX_LONG (MAX_LONG),
    .CNT_W    (CNT_W)
  ) u_busy_tbl (
    .clk      (clk),
    .reset    (reset),
    .set_en   (long_accept && id_we && (id_dest != '0)),
    .set_addr (id_dest),
    .clr_en   (long_wb_valid),
    .clr_addr (long_wb_dest),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .cnt_inc  (long_accept),
    .cnt_dec  (long_wb_valid),
    .long_cnt (long_cnt)
  );

  a_issue_blocked: assert property (@(posedge clk) disable iff (reset)
    !(id_issue && block_id));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: combinational vector table plus multi-cycle sequences.
// Expectations follow HAZARD_FWD_EN when the bench is compiled with it defined.
module tb_hazard_scoreboard;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [1:0]      id_ren;
  logic [1:0][4:0] id_raddr;
  logic            id_we;
  logic [4:0]      id_dest;
  logic            id_long_op;
  logic            id_issue;
  logic [2:0]      stg_valid, stg_we, stg_rdy;
  logic [2:0][4:0] stg_dest;
  logic            long_wb_valid;
  logic [4:0]      long_wb_dest;
  logic            block_id, block_if, br_stall;
  logic [1:0][1:0] fwd_sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_RPORTS(2), .NUM_STG(3), .NREGS(32), .MAX_LONG(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ren(id_ren), .id_raddr(id_raddr),
    .id_we(id_we), .id_dest(id_dest), .id_long_op(id_long_op), .id_issue(id_issue),
    .stg_valid(stg_valid), .stg_we(stg_we), .stg_dest(stg_dest), .stg_rdy(stg_rdy),
    .long_wb_valid(long_wb_valid), .long_wb_dest(long_wb_dest),
    .block_id(block_id), .block_if(block_if), .br_stall(br_stall), .fwd_sel(fwd_sel)
  );

  typedef struct {
    logic [1:0] ren;
    logic [4:0] ra0, ra1;
    logic [2:0] sv, swe, srdy;
    logic [4:0] sd0, sd1, sd2;
    logic       valid;
    logic       blk_f, blk_i;
    logic [1:0] f0, f1;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_ren = '0; id_raddr = '0; id_we = 0; id_dest = '0;
    id_long_op = 0; id_issue = 0; stg_valid = '0; stg_we = '0; stg_dest = '0;
    stg_rdy = '0; long_wb_valid = 0; long_wb_dest = '0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic chk_blk(input string name, input logic exp);
    #2;
    chk({name, ".block_id"}, 32'(block_id), 32'(exp));
    chk({name, ".block_if"}, 32'(block_if), 32'(exp));
    chk({name, ".br_stall"}, 32'(br_stall), 32'(exp));
  endtask

  initial begin
    vecs[0]  = '{2'b11, 5, 6, 3'b111, 3'b111, 3'b111, 1, 2, 3, 1, 0, 0, 0, 0};
    vecs[1]  = '{2'b11, 5, 6, 3'b111, 3'b111, 3'b111, 5, 2, 3, 1, 0, 1, 1, 0};
    vecs[2]  = '{2'b11, 4, 6, 3'b111, 3'b111, 3'b111, 1, 6, 3, 1, 0, 1, 0, 2};
    vecs[3]  = '{2'b11, 5, 5, 3'b111, 3'b111, 3'b111, 1, 2, 5, 1, 0, 1, 3, 3};
    vecs[4]  = '{2'b11, 5, 6, 3'b111, 3'b111, 3'b111, 5, 2, 5, 1, 0, 1, 1, 0};
    vecs[5]  = '{2'b11, 7, 1, 3'b111, 3'b111, 3'b110, 7, 7, 3, 1, 1, 1, 0, 0};
    vecs[6]  = '{2'b11, 7, 1, 3'b111, 3'b110, 3'b110, 7, 7, 3, 1, 0, 1, 2, 0};
    vecs[7]  = '{2'b11, 5, 6, 3'b110, 3'b111, 3'b111, 5, 1, 2, 1, 0, 0, 0, 0};
    vecs[8]  = '{2'b10, 5, 6, 3'b111, 3'b111, 3'b111, 5, 1, 2, 1, 0, 0, 0, 0};
    vecs[9]  = '{2'b11, 0, 0, 3'b111, 3'b111, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{2'b11, 8, 2, 3'b111, 3'b111, 3'b101, 8, 8, 2, 1, 0, 1, 1, 3};
    vecs[11] = '{2'b11, 7, 1, 3'b111, 3'b111, 3'b110, 7, 7, 3, 0, 0, 0, 0, 0};
    vecs[12] = '{2'b11, 4, 7, 3'b111, 3'b111, 3'b101, 1, 7, 3, 1, 1, 1, 0, 0};

    // Reset held with a load-use hazard and a forwardable match present: outputs all 0.
    idle();
    reset = 1;
    step();
    id_valid = 1; id_ren = 2'b11; id_raddr[0] = 7; id_raddr[1] = 5;
    stg_valid = 3'b111; stg_we = 3'b111; stg_rdy = 3'b110;
    stg_dest[0] = 7; stg_dest[1] = 7; stg_dest[2] = 5;
    chk_blk("reset", 0);
    chk("reset.fwd0", 32'(fwd_sel[0]), 0);
    chk("reset.fwd1", 32'(fwd_sel[1]), 0);
    step();
    reset = 0;

    // Combinational vector table.
    for (int i = 0; i < 13; i++) begin
      logic eb;
      step();
      id_valid = vecs[i].valid; id_ren = vecs[i].ren;
      id_raddr[0] = vecs[i].ra0; id_raddr[1] = vecs[i].ra1;
      stg_valid = vecs[i].sv; stg_we = vecs[i].swe; stg_rdy = vecs[i].srdy;
      stg_dest[0] = vecs[i].sd0; stg_dest[1] = vecs[i].sd1; stg_dest[2] = vecs[i].sd2;
      eb = FWD ? vecs[i].blk_f : vecs[i].blk_i;
      chk_blk($sformatf("vec%0d", i), eb);
      if (!eb) begin
        chk($sformatf("vec%0d.fwd0", i), 32'(fwd_sel[0]), FWD ? 32'(vecs[i].f0) : 0);
        chk($sformatf("vec%0d.fwd1", i), 32'(fwd_sel[1]), FWD ? 32'(vecs[i].f1) : 0);
      end
    end

    // Load-use: load in EXE stalls, then forwards from MEM next cycle.
    step();
    id_valid = 1; id_ren = 2'b01; id_raddr[0] = 7;
    stg_valid = 3'b011; stg_we = 3'b011; stg_rdy = 3'b010;
    stg_dest[0] = 7; stg_dest[1] = 7;
    chk_blk("ldu.c0", 1);
    step();
    id_valid = 1; id_ren = 2'b01; id_raddr[0] = 7;
    stg_valid = 3'b010; stg_we = 3'b010; stg_rdy = 3'b010; stg_dest[1] = 7;
    chk_blk("ldu.c1", FWD ? 1'b0 : 1'b1);
    if (FWD) chk("ldu.c1.fwd0", 32'(fwd_sel[0]), 2);

    // Long op to r9: RAW stalls, WAW stalls, writeback releases next cycle.
    step();
    id_valid = 1; id_we = 1; id_dest = 9; id_long_op = 1; id_issue = 1;
    chk_blk("long.issue", 0);
    for (int i = 0; i < 2; i++) begin
      step();
      id_valid = 1; id_ren = 2'b01; id_raddr[0] = 9;
      chk_blk("long.raw", 1);
    end
    step();
    id_valid = 1; id_we = 1; id_dest = 9;
    chk_blk("long.waw", 1);
    step();
    id_valid = 1; id_ren = 2'b01; id_raddr[0] = 9; long_wb_valid = 1; long_wb_dest = 9;
    chk_blk("long.wb_cycle", 1);
    step();
    id_valid = 1; id_ren = 2'b01; id_raddr[0] = 9;
    chk_blk("long.after_wb", 0);

    // Set/clear collision on r3, then fill to capacity; the counter must have stayed at 1.
    step();
    id_valid = 1; id_long_op = 1; id_issue = 1;
    chk_blk("coll.nodest", 0);
    step();
    id_valid = 1; id_long_op = 1; id_issue = 1; id_we = 1; id_dest = 3;
    long_wb_valid = 1; long_wb_dest = 3;
    chk_blk("coll.issue", 0);
    step();
    id_valid = 1; id_ren = 2'b01; id_raddr[0] = 3;
    chk_blk("coll.busy3", 1);
    for (int i = 0; i < 3; i++) begin
      step();
      id_valid = 1; id_long_op = 1; id_issue = 1;
      chk_blk($sformatf("cap.issue%0d", i), 0);
    end
    step();
    id_valid = 1; id_long_op = 1;
    chk_blk("cap.full", 1);
    step();
    id_valid = 1; id_long_op = 1; long_wb_valid = 1; long_wb_dest = 3;
    chk_blk("cap.wb_cycle", 1);
    step();
    id_valid = 1; id_long_op = 1; id_ren = 2'b01; id_raddr[0] = 3;
    chk_blk("cap.after_wb", 0);

    // Reset with busy[9] set and counter full: same-cycle release, state cleared after.
    step();
    id_valid = 1; id_long_op = 1; id_issue = 1; id_we = 1; id_dest = 9;
    chk_blk("rst.issue", 0);
    step();
    reset = 1;
    id_valid = 1; id_long_op = 1; id_ren = 2'b11; id_raddr[0] = 9; id_raddr[1] = 5;
    stg_valid = 3'b001; stg_we = 3'b001; stg_rdy = 3'b001; stg_dest[0] = 5;
    chk_blk("rst.active", 0);
    chk("rst.fwd1", 32'(fwd_sel[1]), 0);
    step();
    reset = 0;
    id_valid = 1; id_long_op = 1; id_ren = 2'b01; id_raddr[0] = 9;
    chk_blk("rst.after", 0);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
